dendrite: RTL and testbench

DENDRITE -- requirements
Module: dendrite

---
 rtl/dendrite.sv | 100 ++++++++++
 tb/tb_dendrite.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dendrite.sv
// Dendrite accumulation pipeline: adds a signed synaptic weight to a neuron's membrane
// potential at full event rate. Forwarding covers in-flight writes. Optional clamping: DENDRITE_SAT_EN.
module dendrite #(
    parameter int NNW = 12,
    parameter int WD  = 6,
    parameter int WW  = 8,
    parameter int VW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           axon_sd_vld,
    input  logic [NNW-1:0] axon_sd_vm_addr,
    input  logic [WD-1:0]  axon_sd_wgt_addr,
    output logic           sd_wgt_re,
    output logic [WD-1:0]  sd_wgt_raddr,
    input  logic [WW-1:0]  sd_wgt_rdata,
    output logic           sd_vm_re,
    output logic [NNW-1:0] sd_vm_raddr,
    input  logic [VW-1:0]  sd_vm_rdata,
    output logic           sd_vm_we,
    output logic [NNW-1:0] sd_vm_waddr,
    output logic [VW-1:0]  sd_vm_wdata,
    output logic           sd_busy
);

    logic           s1_vld;
    logic [NNW-1:0] s1_addr;
    logic           s2_vld;
    logic [NNW-1:0] s2_addr;
    logic [VW-1:0]  s2_data;
    logic           s3_vld;
    logic [NNW-1:0] s3_addr;
    logic [VW-1:0]  s3_data;

    logic [VW-1:0]  operand;
    logic [VW-1:0]  wgt_ext;
    logic [VW-1:0]  sum;

    assign sd_wgt_re    = axon_sd_vld;
    assign sd_vm_re     = axon_sd_vld;
    assign sd_wgt_raddr = axon_sd_wgt_addr;
    assign sd_vm_raddr  = axon_sd_vm_addr;

    assign sd_vm_we    = s2_vld;
    assign sd_vm_waddr = s2_addr;
    assign sd_vm_wdata = s2_data;
    assign sd_busy     = s1_vld | s2_vld;

    assign wgt_ext = {{(VW-WW){sd_wgt_rdata[WW-1]}}, sd_wgt_rdata};

    // The memory read for the S1 event was issued before the S2/S3 writes landed,
    // so the youngest in-flight result for the same neuron takes precedence.
    always_comb begin
        operand = sd_vm_rdata;
        if (s2_vld && (s2_addr == s1_addr)) begin
            operand = s2_data;
        end else if (s3_vld && (s3_addr == s1_addr)) begin
            operand = s3_data;
        end
    end

`ifdef DENDRITE_SAT_EN
    logic [VW:0] sum_wide;

    always_comb begin
        sum_wide = {operand[VW-1], operand} + {wgt_ext[VW-1], wgt_ext};
        sum      = sum_wide[VW-1:0];
        if (sum_wide[VW] != sum_wide[VW-1]) begin
            sum = sum_wide[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
        end
    end
`else
    always_comb begin
        sum = operand + wgt_ext;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_addr <= '0;
            s2_vld  <= 1'b0;
            s2_addr <= '0;
            s2_data <= '0;
            s3_vld  <= 1'b0;
            s3_addr <= '0;
            s3_data <= '0;
        end else begin
            s1_vld  <= axon_sd_vld;
            s1_addr <= axon_sd_vm_addr;
            s2_vld  <= s1_vld;
            s2_addr <= s1_addr;
            s2_data <= sum;
            s3_vld  <= s2_vld;
            s3_addr <= s2_addr;
            s3_data <= s2_data;
        end
    end

endmodule

// File: tb/tb_dendrite.sv
// Directed bench for dendrite: behavioural weight/membrane memories plus a write monitor,
// hand-computed expected writes, cycle positions and busy durations.
module tb_dendrite;
    localparam int NNW = 12;
    localparam int WD  = 6;
    localparam int WW  = 8;
    localparam int VW  = 16;

    logic           clk;
    logic           rst_n;
    logic           axon_sd_vld;
    logic [NNW-1:0] axon_sd_vm_addr;
    logic [WD-1:0]  axon_sd_wgt_addr;
    logic           sd_wgt_re;
    logic [WD-1:0]  sd_wgt_raddr;
    logic [WW-1:0]  sd_wgt_rdata;
    logic           sd_vm_re;
    logic [NNW-1:0] sd_vm_raddr;
    logic [VW-1:0]  sd_vm_rdata;
    logic           sd_vm_we;
    logic [NNW-1:0] sd_vm_waddr;
    logic [VW-1:0]  sd_vm_wdata;
    logic           sd_busy;

    dendrite #(.NNW(NNW), .WD(WD), .WW(WW), .VW(VW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .axon_sd_vld      (axon_sd_vld),
        .axon_sd_vm_addr  (axon_sd_vm_addr),
        .axon_sd_wgt_addr (axon_sd_wgt_addr),
        .sd_wgt_re        (sd_wgt_re),
        .sd_wgt_raddr     (sd_wgt_raddr),
        .sd_wgt_rdata     (sd_wgt_rdata),
        .sd_vm_re         (sd_vm_re),
        .sd_vm_raddr      (sd_vm_raddr),
        .sd_vm_rdata      (sd_vm_rdata),
        .sd_vm_we         (sd_vm_we),
        .sd_vm_waddr      (sd_vm_waddr),
        .sd_vm_wdata      (sd_vm_wdata),
        .sd_busy          (sd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memories with one-cycle read latency; a colliding read returns the old word.
    logic [VW-1:0]  vm_mem [0:(1<<NNW)-1];
    logic [WW-1:0]  wgt_mem[0:(1<<WD)-1];
    logic           pre_vm_we = 1'b0;
    logic           pre_wgt_we = 1'b0;
    logic [NNW-1:0] pre_addr = '0;
    logic [VW-1:0]  pre_data = '0;

    always @(posedge clk) begin
        if (sd_vm_re)  sd_vm_rdata  <= vm_mem[sd_vm_raddr];
        if (sd_wgt_re) sd_wgt_rdata <= wgt_mem[sd_wgt_raddr];
        if (sd_vm_we)  vm_mem[sd_vm_waddr] <= sd_vm_wdata;
        if (pre_vm_we)  vm_mem[pre_addr] <= pre_data;
        if (pre_wgt_we) wgt_mem[pre_addr[WD-1:0]] <= pre_data[WW-1:0];
    end

    logic [NNW-1:0] log_addr[$];
    logic [VW-1:0]  log_data[$];
    int             log_cyc[$];
    int             busy_cnt = 0;

    always @(negedge clk) begin
        if (sd_vm_we) begin
            log_addr.push_back(sd_vm_waddr);
            log_data.push_back(sd_vm_wdata);
            log_cyc.push_back(cyc);
        end
        if (sd_busy) busy_cnt <= busy_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    int base;
    int busy_base;
    int t0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_vm(input logic [NNW-1:0] a, input logic [VW-1:0] d);
        @(negedge clk);
        pre_vm_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_vm_we = 1'b0;
    endtask

    task automatic load_wgt(input logic [WD-1:0] a, input logic [WW-1:0] d);
        @(negedge clk);
        pre_wgt_we = 1'b1; pre_addr = NNW'(a); pre_data = VW'(d);
        @(negedge clk);
        pre_wgt_we = 1'b0;
    endtask

    task automatic ev(input logic [NNW-1:0] a, input logic [WD-1:0] w);
        @(negedge clk);
        axon_sd_vld = 1'b1; axon_sd_vm_addr = a; axon_sd_wgt_addr = w;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            axon_sd_vld = 1'b0;
        end
    endtask

    task automatic mark();
        @(negedge clk);
        base = log_addr.size();
        busy_base = busy_cnt;
    endtask

    task automatic expect_wr(input string tag, input int idx, input logic [NNW-1:0] a,
                             input logic [VW-1:0] d, input int c);
        if (log_addr.size() > base + idx) begin
            check({tag, "_addr"}, 32'(log_addr[base+idx]), 32'(a));
            check({tag, "_data"}, 32'(log_data[base+idx]), 32'(d));
            check({tag, "_cyc"},  32'(log_cyc[base+idx]),  32'(c));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        axon_sd_vld = 1'b0;
        axon_sd_vm_addr = '0;
        axon_sd_wgt_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_we",    32'(sd_vm_we),    32'd0);
        check("rst_waddr", 32'(sd_vm_waddr), 32'd0);
        check("rst_wdata", 32'(sd_vm_wdata), 32'd0);
        check("rst_busy",  32'(sd_busy),     32'd0);
        rst_n = 1'b1;

        // single event: 100 + 7 -> 107, two cycles after acceptance
        load_vm(12'd5, 16'd100);
        load_wgt(6'd3, 8'd7);
        mark();
        ev(12'd5, 6'd3);
        t0 = cyc;
        #1;
        check("rd_vm_re",     32'(sd_vm_re),     32'd1);
        check("rd_wgt_re",    32'(sd_wgt_re),    32'd1);
        check("rd_vm_raddr",  32'(sd_vm_raddr),  32'd5);
        check("rd_wgt_raddr", 32'(sd_wgt_raddr), 32'd3);
        idle(6);
        check("single_count", 32'(log_addr.size() - base), 32'd1);
        expect_wr("single", 0, 12'd5, 16'd107, t0 + 2);
        check("single_busy", 32'(busy_cnt - busy_base), 32'd2);
        check("idle_re", 32'(sd_vm_re), 32'd0);

        // back-to-back on one neuron: S2 forwarding
        load_vm(12'd9, 16'd0);
        load_wgt(6'd1, 8'd3);
        mark();
        ev(12'd9, 6'd1);
        t0 = cyc;
        ev(12'd9, 6'd1);
        ev(12'd9, 6'd1);
        ev(12'd9, 6'd1);
        idle(8);
        check("b2b_count", 32'(log_addr.size() - base), 32'd4);
        expect_wr("b2b0", 0, 12'd9, 16'd3,  t0 + 2);
        expect_wr("b2b1", 1, 12'd9, 16'd6,  t0 + 3);
        expect_wr("b2b2", 2, 12'd9, 16'd9,  t0 + 4);
        expect_wr("b2b3", 3, 12'd9, 16'd12, t0 + 5);
        check("b2b_busy", 32'(busy_cnt - busy_base), 32'd5);

        // gap-of-one: 4, 8, 4 -> S3 forwarding
        load_vm(12'd4, 16'd10);
        load_vm(12'd8, 16'd0);
        load_wgt(6'd2, 8'd2);
        mark();
        ev(12'd4, 6'd2);
        t0 = cyc;
        ev(12'd8, 6'd2);
        ev(12'd4, 6'd2);
        idle(8);
        check("gap_count", 32'(log_addr.size() - base), 32'd3);
        expect_wr("gap0", 0, 12'd4, 16'd12, t0 + 2);
        expect_wr("gap1", 1, 12'd8, 16'd2,  t0 + 3);
        expect_wr("gap2", 2, 12'd4, 16'd14, t0 + 4);

        // negative weight: 5 + (-8) = -3
        load_vm(12'd0, 16'd5);
        load_wgt(6'd10, 8'hF8);
        mark();
        ev(12'd0, 6'd10);
        t0 = cyc;
        idle(6);
        check("neg_count", 32'(log_addr.size() - base), 32'd1);
        expect_wr("neg", 0, 12'd0, 16'hFFFD, t0 + 2);

        // positive overflow: 32760 + 20
        load_vm(12'd2, 16'd32760);
        load_wgt(6'd11, 8'd20);
        mark();
        ev(12'd2, 6'd11);
        t0 = cyc;
        idle(6);
        check("sat_count", 32'(log_addr.size() - base), 32'd1);
`ifdef DENDRITE_SAT_EN
        expect_wr("sat_pos", 0, 12'd2, 16'h7FFF, t0 + 2);
`else
        expect_wr("sat_pos", 0, 12'd2, 16'h800C, t0 + 2);
`endif

        // negative overflow: -32768 + (-1)
        load_vm(12'd3, 16'h8000);
        load_wgt(6'd12, 8'hFF);
        mark();
        ev(12'd3, 6'd12);
        t0 = cyc;
        idle(6);
`ifdef DENDRITE_SAT_EN
        expect_wr("sat_neg", 0, 12'd3, 16'h8000, t0 + 2);
`else
        expect_wr("sat_neg", 0, 12'd3, 16'h7FFF, t0 + 2);
`endif

        // reset while the event sits in S1: nothing must be written afterwards
        load_vm(12'd6, 16'd1);
        ev(12'd6, 6'd3);
        @(negedge clk);
        axon_sd_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we",    32'(sd_vm_we),    32'd0);
        check("mid_rst_waddr", 32'(sd_vm_waddr), 32'd0);
        check("mid_rst_wdata", 32'(sd_vm_wdata), 32'd0);
        check("mid_rst_busy",  32'(sd_busy),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        base = log_addr.size();
        busy_base = busy_cnt;
        idle(6);
        check("post_rst_writes", 32'(log_addr.size() - base), 32'd0);
        check("post_rst_busy",   32'(busy_cnt - busy_base),   32'd0);
        check("post_rst_busy_now", 32'(sd_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
